noc_local_tx: RTL

- Tile-side packetizer. Converts a request (destination, message type, payload length) plus a payload word stream into head/body/tail flits.
- Drives the local (P) input port of a mesh router: `data_p_in` on the router side, `data_out` here.
- Uses the router's void/stop handshake.
- Registered output with full-throughput reload: one flit per cycle when not stopped; back-to-back packets have no bubbles.

---
 rtl/noc_local_tx.sv | 110 +++++++++++
 1 files changed

// File: rtl/noc_local_tx.sv
// noc_local_tx: tile-side packetizer feeding the local (P) port of a mesh router.
// A request (destination, message type, payload length) becomes one head flit,
// followed by req_len body flits taken from the payload stream. The last flit
// carries the tail bit. Flits leave through a single output register that
// reloads at full rate, so back-to-back packets are sent without bubbles.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   CONST_localx/CONST_localy   static source coordinates
//   req_valid/req_ready         request handshake
//   req_dst_x/req_dst_y         destination coordinates
//   req_msg, req_len            message type, payload flit count (0 = head only)
//   payload_valid/payload_ready payload word handshake
//   payload_data                payload word
//   data_out, data_void_out     flit to router, 1 = no flit
//   stop_in                     router backpressure
//   pkt_sent                    high in the cycle a tail flit transfers
module noc_local_tx #(
  parameter int unsigned Width = 34,
  parameter int unsigned XW    = 3,
  parameter int unsigned YW    = 3,
  parameter int unsigned MSGW  = 5,
  parameter int unsigned LENW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XW-1:0]         CONST_localx,
  input  logic [YW-1:0]         CONST_localy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [XW-1:0]         req_dst_x,
  input  logic [YW-1:0]         req_dst_y,
  input  logic [MSGW-1:0]       req_msg,
  input  logic [LENW-1:0]       req_len,
  input  logic                  payload_valid,
  output logic                  payload_ready,
  input  logic [Width-3:0]      payload_data,
  output logic [Width-1:0]      data_out,
  output logic                  data_void_out,
  input  logic                  stop_in,
  output logic                  pkt_sent
);

  localparam int unsigned DataWidth = Width - 2;
  localparam int unsigned HdrW      = 2*XW + 2*YW + MSGW;

  if (DataWidth < HdrW) begin : g_width_check
    $fatal(1, "noc_local_tx: Width-2 is too small to hold the header fields");
  end

  typedef enum logic {IDLE, PAYLOAD} state_e;

  state_e                 state_q;
  logic [LENW-1:0]        count_q;
  logic [Width-1:0]       data_q;
  logic                   void_q;

  logic                   load_ok;
  logic                   req_acc;
  logic                   pay_acc;
  logic                   last_word;
  logic [DataWidth-1:0]   hdr_bits;

  // The output register may take a new flit when it is empty or being drained.
  assign load_ok       = void_q | ~stop_in;
  assign req_ready     = rst & (state_q == IDLE)    & load_ok;
  assign payload_ready = rst & (state_q == PAYLOAD) & load_ok;
  assign req_acc       = req_valid & req_ready;
  assign pay_acc       = payload_valid & payload_ready;
  assign last_word     = (count_q == LENW'(1));

  // Header fields packed at the top of the data field, unused LSBs zero.
  always_comb begin
    hdr_bits = '0;
    hdr_bits[DataWidth-1 -: HdrW] = {CONST_localy, CONST_localx, req_dst_y, req_dst_x, req_msg};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      data_q  <= '0;
      void_q  <= 1'b1;
    end else if (load_ok) begin
      if (req_acc) begin
        data_q <= {1'b1, (req_len == '0), hdr_bits};
        void_q <= 1'b0;
        if (req_len != '0) begin
          state_q <= PAYLOAD;
          count_q <= req_len;
        end
      end else if (pay_acc) begin
        data_q  <= {1'b0, last_word, payload_data};
        void_q  <= 1'b0;
        count_q <= count_q - LENW'(1);
        if (last_word) begin
          state_q <= IDLE;
        end
      end else begin
        // Nothing to load: go void, data_q keeps its last value.
        void_q <= 1'b1;
      end
    end
  end

  assign data_out      = data_q;
  assign data_void_out = void_q;
  assign pkt_sent      = ~void_q & ~stop_in & data_q[Width-2];

endmodule
